up_down_mod_counter: RTL and testbench
======================================

UP_DOWN_MOD_COUNTER -- requirements
Module: up_down_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: count register width in bits.
REQ-002 Parameter MODULUS, default 10: count sequence length; legal range 2 to 2**WIDTH.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous active-low reset; 0 resets all state immediately.
REQ-005 Port en, input, 1: count enable; 1 = step this cycle.
REQ-006 Port mode, input, 1: direction; 1 = up, 0 = down.
REQ-007 Port load, input, 1: synchronous parallel load strobe.
REQ-008 Port load_val, input, WIDTH: value loaded when load=1.
REQ-009 Port count, output, WIDTH: registered counter value.
REQ-010 Port tc, output, 1: combinational terminal-count flag.
REQ-011 Port ovf, output, 1: registered one-cycle boundary event pulse.

Function
REQ-012 count SHALL always remain in range 0 to MODULUS-1.
REQ-013 Per-edge priority SHALL be: load first, then en, then hold.
REQ-014 load=1 SHALL set count to load_val next edge, regardless of en and mode.
REQ-015 load_val >= MODULUS SHALL clamp: count becomes MODULUS-1.
REQ-016 load SHALL NOT assert ovf.
REQ-017 en=1, load=0, mode=1, count < MODULUS-1: count SHALL become count+1.
REQ-018 en=1, load=0, mode=0, count > 0: count SHALL become count-1.
REQ-019 en=0, load=0: count SHALL hold its value and ovf SHALL be 0 next cycle.
REQ-020 Direction SHALL be sampled every edge; a mode change takes effect on the same edge.
REQ-020a A mode change SHALL carry no extra latency.
REQ-021 tc SHALL be 1 when en=1, load=0, and either mode=1 with count=MODULUS-1, or mode=0 with count=0.
REQ-021a tc SHALL be 0 otherwise.
REQ-022 ovf SHALL be 1 for exactly the one cycle after an edge where tc=1.
REQ-022a ovf SHALL be 0 in all other cycles.
REQ-023 Continuous boundary steps SHALL produce ovf=1 on each consecutive cycle; no gaps, no merging.
REQ-024 Arithmetic SHALL NOT produce out-of-range intermediates at WIDTH bits when MODULUS=2**WIDTH.
REQ-024a Wrap SHALL be explicit, not natural rollover.

Reset
REQ-025 rst=0 SHALL set count=0 and ovf=0 asynchronously, without waiting for clk.
REQ-026 While rst=0, count and ovf SHALL hold 0 and ignore en, load and mode.
REQ-027 After rst rises, the first rising clk edge SHALL apply normal function.
REQ-028 Reset asserted mid-count or mid-load SHALL discard the pending step or load.
REQ-029 tc SHALL follow REQ-021 from the reset value count=0; mode=0 with en=1 gives tc=1.

Configuration
REQ-030 Macro UP_DOWN_SATURATE_EN SHALL select saturating behaviour at compile time.
REQ-031 Without UP_DOWN_SATURATE_EN, a boundary step SHALL wrap.
REQ-031a Up-wrap SHALL go MODULUS-1 -> 0; down-wrap SHALL go 0 -> MODULUS-1.
REQ-032 With UP_DOWN_SATURATE_EN, a boundary step SHALL leave count unchanged.
REQ-032a Under saturation, tc and ovf SHALL still assert per REQ-021/REQ-022, flagging the blocked step.
REQ-033 Port list, reset and load behaviour SHALL be identical in both builds.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-034 rst=0 mid-count at count=7 between edges -> count=0 and ovf=0 immediately; count stays 0 until the first edge after rst=1.
REQ-035 en=1, mode=1 for 12 edges from 0:
- count runs 1..9, 0, 1, 2;
- tc=1 while count=9;
- ovf=1 only in the cycle count=0;
- with macro: count sticks at 9 and ovf=1 on every edge from the 10th.
REQ-036 en=1, mode=0 from count=0 -> next count=9 and ovf=1 (wrap build); with macro, count=0 and ovf=1.
REQ-037 Load checks:
- load=1, load_val=4, en=1, mode=1 -> count=4, not 5, and ovf=0;
- load_val=13 -> count=9.
REQ-038 en=1 with mode toggled each cycle from count=5 -> count alternates 6, 5, 6, 5 and ovf stays 0.
REQ-039 WIDTH=3, MODULUS=8, en=1, mode=1 from 7 -> count=0 and ovf=1; reverse from 0 -> count=7 and ovf=1.

Source files
------------

// File: rtl/up_down_mod_counter.sv
// Up/down modulo-MODULUS counter with parallel load, terminal-count flag and overflow pulse.
// Define UP_DOWN_SATURATE_EN to make boundary steps hold the count instead of wrapping.
module up_down_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so MODULUS = 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_clamped;
  logic             ovf_reg;
  logic             at_boundary;

  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
  assign at_boundary  = mode ? (count_reg == MAX_VAL) : (count_reg == '0);
  assign tc           = en & ~load & at_boundary;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (at_boundary) begin
`ifdef UP_DOWN_SATURATE_EN
        count_next = count_reg;
`else
        count_next = mode ? '0 : MAX_VAL;
`endif
      end else begin
        // Boundary excluded above, so neither direction can leave 0..MODULUS-1.
        count_next = mode ? (count_reg + ONE) : (count_reg - ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= tc;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Directed self-checking bench for up_down_mod_counter (default wrap build).
// Covers the 4-bit/mod-10 instance and a 3-bit/mod-8 instance for full-range wrap.
module tb_up_down_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       en0 = 1'b0, mode0 = 1'b0, load0 = 1'b0;
  logic [3:0] load_val0 = '0;
  logic [3:0] count0;
  logic       tc0, ovf0;

  logic       en1 = 1'b0, mode1 = 1'b0, load1 = 1'b0;
  logic [2:0] load_val1 = '0;
  logic [2:0] count1;
  logic       tc1, ovf1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  up_down_mod_counter #(.WIDTH(4), .MODULUS(10)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .mode(mode0), .load(load0),
    .load_val(load_val0), .count(count0), .tc(tc0), .ovf(ovf0)
  );

  up_down_mod_counter #(.WIDTH(3), .MODULUS(8)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .load(load1),
    .load_val(load_val1), .count(count1), .tc(tc1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input int v);
    load0 = 1'b1; load_val0 = 4'(v);
    step();
    load0 = 1'b0;
  endtask

  int cur;
  int prev;

  initial begin
    // Reset held from time 0, before any clock edge.
    #3;
    chk("rst_count", int'(count0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    en0 = 1'b1; mode0 = 1'b0;
    #1;
    chk("rst_tc_down", int'(tc0), 1);
    load0 = 1'b1; load_val0 = 4'd6; mode0 = 1'b1;
    step();
    chk("rst_ignores_load", int'(count0), 0);
    chk("rst_ignores_ovf", int'(ovf0), 0);
    load0 = 1'b0;

    // Release reset well away from an edge; first edge counts.
    rst = 1'b1;
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("up_tc_%0d", i), int'(tc0), (cur == 9) ? 1 : 0);
      prev = cur;
      step();
      cur = (cur + 1) % 10;
      chk($sformatf("up_cnt_%0d", i), int'(count0), cur);
      chk($sformatf("up_ovf_%0d", i), int'(ovf0), (prev == 9) ? 1 : 0);
    end

    // Down wrap from 0, then hold with en=0.
    load4(0);
    chk("ld0_ovf", int'(ovf0), 0);
    mode0 = 1'b0;
    #1;
    chk("dn_tc", int'(tc0), 1);
    step();
    chk("dn_wrap_cnt", int'(count0), 9);
    chk("dn_wrap_ovf", int'(ovf0), 1);
    en0 = 1'b0;
    #1;
    chk("hold_tc", int'(tc0), 0);
    step();
    chk("hold_cnt", int'(count0), 9);
    chk("hold_ovf", int'(ovf0), 0);

    // Load beats enable; clamping of out-of-range values.
    en0 = 1'b1; mode0 = 1'b1;
    load4(4);
    chk("ld4_cnt", int'(count0), 4);
    chk("ld4_ovf", int'(ovf0), 0);
    load4(13);
    chk("ld13_cnt", int'(count0), 9);
    load0 = 1'b1; load_val0 = 4'd3;
    #1;
    chk("ld_at9_tc", int'(tc0), 0);
    step();
    load0 = 1'b0;
    chk("ld_at9_cnt", int'(count0), 3);
    chk("ld_at9_ovf", int'(ovf0), 0);
    load4(15);
    chk("ld15_cnt", int'(count0), 9);

    // Mode toggled every cycle from 5.
    load4(5);
    for (int i = 0; i < 4; i++) begin
      mode0 = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("tog_cnt_%0d", i), int'(count0), (i % 2 == 0) ? 6 : 5);
      chk($sformatf("tog_ovf_%0d", i), int'(ovf0), 0);
    end

    // Async reset while ovf is high clears it without an edge.
    load4(9);
    mode0 = 1'b1;
    step();
    chk("pre_rst_ovf", int'(ovf0), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ovf_clr", int'(ovf0), 0);
    #1 rst = 1'b1;

    // Async reset mid-count at 7.
    load4(7);
    en0 = 1'b1; mode0 = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst7_cnt", int'(count0), 0);
    chk("arst7_ovf", int'(ovf0), 0);
    step();
    chk("rst_hold_cnt", int'(count0), 0);
    rst = 1'b1;
    step();
    chk("rel_first_cnt", int'(count0), 1);

    // 3-bit, modulus 8: full-range wrap both ways, back-to-back ovf.
    en0 = 1'b0;
    en1 = 1'b1; mode1 = 1'b1; load1 = 1'b1; load_val1 = 3'd7;
    step();
    load1 = 1'b0;
    chk("w3_ld7", int'(count1), 7);
    step();
    chk("w3_up_cnt", int'(count1), 0);
    chk("w3_up_ovf", int'(ovf1), 1);
    mode1 = 1'b0;
    step();
    chk("w3_dn_cnt", int'(count1), 7);
    chk("w3_dn_ovf", int'(ovf1), 1);
    step();
    chk("w3_dn2_cnt", int'(count1), 6);
    chk("w3_dn2_ovf", int'(ovf1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
